// File: rtl/imuldivu_acc_if.sv
// Execute-stage handshake between the core and the multiply/divide unit.
// Field names follow the unit's existing i_/o_ port naming.
interface imuldivu_acc_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_valid;
    logic [3:0]       i_op;
    logic [WIDTH-1:0] i_rs_val;
    logic [WIDTH-1:0] i_rt_val;
    logic             i_cancel;
    logic             o_stall;
    logic             o_busy;
    logic [WIDTH-1:0] o_rd_val;
    logic             o_rd_valid;
    logic             o_dz;

    modport master (
        output i_valid, i_op, i_rs_val, i_rt_val, i_cancel,
        input  o_stall, o_busy, o_rd_val, o_rd_valid, o_dz
    );

    modport slave (
        input  i_valid, i_op, i_rs_val, i_rt_val, i_cancel,
        output o_stall, o_busy, o_rd_val, o_rd_valid, o_dz
    );
endinterface

// File: rtl/imuldivu_acc.sv
// Iterative multiply/divide/multiply-accumulate unit owning the HI:LO pair.
// Shift-add multiplier (MUL_BITS per cycle) and 1-bit/cycle restoring divider.
module imuldivu_acc #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_BITS = 2
) (
    input logic           clk,
    input logic           nrst,
    imuldivu_acc_if.slave bus
);
    localparam int unsigned N  = WIDTH / MUL_BITS;
    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OpNop   = 4'd0;
    localparam logic [3:0] OpMfhi  = 4'd1;
    localparam logic [3:0] OpMflo  = 4'd2;
    localparam logic [3:0] OpMthi  = 4'd3;
    localparam logic [3:0] OpMtlo  = 4'd4;
    localparam logic [3:0] OpMult  = 4'd5;
    localparam logic [3:0] OpDiv   = 4'd7;
    localparam logic [3:0] OpDivu  = 4'd8;
    localparam logic [3:0] OpMadd  = 4'd9;
    localparam logic [3:0] OpMsub  = 4'd11;
    localparam logic [3:0] OpMsubu = 4'd12;

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StAcc} state_e;

    state_e            state_q;
    logic [W2-1:0]     hilo_q, acc_q, mcand_q;
    logic [WIDTH-1:0]  mplier_q, rd_val_q;
    logic [CW-1:0]     cnt_q;
    logic              sign_q, rsign_q, div_q, accum_q, sub_q;
    logic              busy_q, rd_valid_q, dz_q;

    logic [3:0]        op;
    logic [WIDTH-1:0]  rs, rt, rs_mag, rt_mag;
    logic              op_live, accept, op_signed, rs_neg, rt_neg;

    assign op        = bus.i_op;
    assign rs        = bus.i_rs_val;
    assign rt        = bus.i_rt_val;
    assign op_live   = (op != OpNop) && (op <= OpMsubu);
    assign accept    = bus.i_valid && !busy_q && !bus.i_cancel && op_live;
    assign op_signed = (op == OpMult) || (op == OpDiv) || (op == OpMadd) || (op == OpMsub);
    assign rs_neg    = op_signed && rs[WIDTH-1];
    assign rt_neg    = op_signed && rt[WIDTH-1];
    assign rs_mag    = rs_neg ? -rs : rs;
    assign rt_mag    = rt_neg ? -rt : rt;

    assign bus.o_stall    = bus.i_valid && busy_q && !bus.i_cancel && op_live;
    assign bus.o_busy     = busy_q;
    assign bus.o_rd_val   = rd_val_q;
    assign bus.o_rd_valid = rd_valid_q;
    assign bus.o_dz       = dz_q;

    logic [W2-1:0]    mul_next, div_next, fix_val, acc_sum;
    logic [W2:0]      div_sh;
    logic [WIDTH:0]   div_dif;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign mul_next = acc_q + mcand_q * {{(W2-MUL_BITS){1'b0}}, mplier_q[MUL_BITS-1:0]};

    // Remainder lives in acc_q's upper half, dividend/quotient in the lower half.
    assign div_sh   = {acc_q, 1'b0};
    assign div_dif  = div_sh[W2:WIDTH] - {1'b0, mplier_q};
    assign div_next = div_dif[WIDTH] ? div_sh[W2-1:0]
                                     : {div_dif[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};

    assign quo_fix = sign_q  ? -acc_q[WIDTH-1:0]  : acc_q[WIDTH-1:0];
    assign rem_fix = rsign_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
    assign fix_val = div_q ? {rem_fix, quo_fix} : (sign_q ? -acc_q : acc_q);
    assign acc_sum = sub_q ? hilo_q - acc_q : hilo_q + acc_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= StIdle;
            hilo_q     <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            rsign_q    <= 1'b0;
            div_q      <= 1'b0;
            accum_q    <= 1'b0;
            sub_q      <= 1'b0;
            busy_q     <= 1'b0;
            rd_val_q   <= '0;
            rd_valid_q <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            dz_q       <= 1'b0;
            if (busy_q && bus.i_cancel) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (accept) begin
                            case (op)
                                OpMfhi: begin
                                    rd_val_q   <= hilo_q[W2-1:WIDTH];
                                    rd_valid_q <= 1'b1;
                                end
                                OpMflo: begin
                                    rd_val_q   <= hilo_q[WIDTH-1:0];
                                    rd_valid_q <= 1'b1;
                                end
                                OpMthi: hilo_q[W2-1:WIDTH] <= rs;
                                OpMtlo: hilo_q[WIDTH-1:0]  <= rs;
                                OpDiv, OpDivu: begin
                                    if (rt == '0) begin
                                        hilo_q <= {rs, {WIDTH{1'b1}}};
                                        dz_q   <= 1'b1;
                                    end else begin
                                        state_q  <= StDiv;
                                        busy_q   <= 1'b1;
                                        acc_q    <= {{WIDTH{1'b0}}, rs_mag};
                                        mplier_q <= rt_mag;
                                        cnt_q    <= CW'(WIDTH);
                                        sign_q   <= rs_neg ^ rt_neg;
                                        rsign_q  <= rs_neg;
                                        div_q    <= 1'b1;
                                        accum_q  <= 1'b0;
                                        sub_q    <= 1'b0;
                                    end
                                end
                                default: begin
                                    state_q  <= StMul;
                                    busy_q   <= 1'b1;
                                    acc_q    <= '0;
                                    mcand_q  <= {{WIDTH{1'b0}}, rs_mag};
                                    mplier_q <= rt_mag;
                                    cnt_q    <= CW'(N);
                                    sign_q   <= rs_neg ^ rt_neg;
                                    rsign_q  <= 1'b0;
                                    div_q    <= 1'b0;
                                    accum_q  <= (op >= OpMadd);
                                    sub_q    <= (op >= OpMsub);
                                end
                            endcase
                        end
                    end
                    StMul: begin
                        acc_q    <= mul_next;
                        mcand_q  <= mcand_q << MUL_BITS;
                        mplier_q <= mplier_q >> MUL_BITS;
                        cnt_q    <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) state_q <= StFix;
                    end
                    StDiv: begin
                        acc_q <= div_next;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) state_q <= StFix;
                    end
                    StFix: begin
                        if (accum_q) begin
                            acc_q   <= fix_val;
                            state_q <= StAcc;
                        end else begin
                            hilo_q  <= fix_val;
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                    StAcc: begin
                        hilo_q  <= acc_sum;
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imuldivu_acc.sv
// Self-checking bench for imuldivu_acc: vector table, hand sequences for
// stall/cancel/reset corners, and randomized ops against an arithmetic model.
module tb_imuldivu_acc;
    localparam int unsigned WIDTH    = 32;
    localparam int unsigned MUL_BITS = 2;
    localparam int unsigned N        = WIDTH / MUL_BITS;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    imuldivu_acc_if #(.WIDTH(WIDTH)) bus ();
    imuldivu_acc #(.WIDTH(WIDTH), .MUL_BITS(MUL_BITS)) dut (.clk(clk), .nrst(nrst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] m_hi, m_lo;
    int          m_lat;
    bit          m_dz;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        bit          dz;
    } vec_t;
    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on HI:LO.
    function automatic void model(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        longint sa, sb, ua, ub, q, r;
        logic [63:0] ps, pu, hl, qv, rv;
        sa = longint'($signed(rs));
        sb = longint'($signed(rt));
        ua = longint'({32'h0, rs});
        ub = longint'({32'h0, rt});
        ps = 64'(sa * sb);
        pu = {32'h0, rs} * {32'h0, rt};
        hl = {m_hi, m_lo};
        m_dz  = 1'b0;
        m_lat = 0;
        case (op)
            4'd3: hl[63:32] = rs;
            4'd4: hl[31:0]  = rs;
            4'd5: begin hl = ps;      m_lat = N + 1; end
            4'd6: begin hl = pu;      m_lat = N + 1; end
            4'd9: begin hl = hl + ps; m_lat = N + 2; end
            4'd10: begin hl = hl + pu; m_lat = N + 2; end
            4'd11: begin hl = hl - ps; m_lat = N + 2; end
            4'd12: begin hl = hl - pu; m_lat = N + 2; end
            4'd7, 4'd8: begin
                if (rt == 32'h0) begin
                    hl   = {rs, 32'hFFFF_FFFF};
                    m_dz = 1'b1;
                end else begin
                    q = (op == 4'd7) ? sa / sb : ua / ub;
                    r = (op == 4'd7) ? sa % sb : ua % ub;
                    qv = 64'(q);
                    rv = 64'(r);
                    hl = {rv[31:0], qv[31:0]};
                    m_lat = WIDTH + 1;
                end
            end
            default: ;
        endcase
        {m_hi, m_lo} = hl;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         output int lat, output bit dz_seen);
        @(negedge clk);
        bus.i_valid  = 1'b1;
        bus.i_op     = op;
        bus.i_rs_val = rs;
        bus.i_rt_val = rt;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_op    = 4'd0;
        dz_seen = bus.o_dz;
        lat = 0;
        while (bus.o_busy && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        model(op, rs, rt);
    endtask

    task automatic read(input logic [3:0] op, output logic [31:0] v);
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_op    = op;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_op    = 4'd0;
        check("rd_valid set", 64'(bus.o_rd_valid), 64'd1);
        v = bus.o_rd_val;
        @(posedge clk);
        #1;
        check("rd_valid one cycle", 64'(bus.o_rd_valid), 64'd0);
    endtask

    task automatic check_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
        logic [31:0] v;
        read(4'd1, v);
        check({name, " HI"}, 64'(v), 64'(hi));
        read(4'd2, v);
        check({name, " LO"}, 64'(v), 64'(lo));
    endtask

    initial begin
        int lat;
        bit dz;
        int stall_cnt;
        logic [3:0]  op;
        logic [31:0] rs, rt;

        vecs[0]  = '{4'd5,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 17, 1'b0};
        vecs[1]  = '{4'd6,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 17, 1'b0};
        vecs[2]  = '{4'd7,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0};
        vecs[3]  = '{4'd7,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 33, 1'b0};
        vecs[4]  = '{4'd8,  32'd5,        32'd0,        32'd5,        32'hFFFF_FFFF, 0,  1'b1};
        vecs[5]  = '{4'd3,  32'd0,        32'd0,        32'd0,        32'hFFFF_FFFF, 0,  1'b0};
        vecs[6]  = '{4'd4,  32'd10,       32'd0,        32'd0,        32'd10,       0,  1'b0};
        vecs[7]  = '{4'd9,  32'd3,        32'd4,        32'd0,        32'd22,       18, 1'b0};
        vecs[8]  = '{4'd12, 32'd1,        32'd30,       32'hFFFF_FFFF, 32'hFFFF_FFF8, 18, 1'b0};
        vecs[9]  = '{4'd7,  32'd7,        32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 33, 1'b0};
        vecs[10] = '{4'd8,  32'd100,      32'd7,        32'd2,        32'd14,       33, 1'b0};
        vecs[11] = '{4'd11, 32'hFFFF_FFFE, 32'd3,        32'd2,        32'd20,       18, 1'b0};
        vecs[12] = '{4'd10, 32'hFFFF_FFFF, 32'd2,        32'd4,        32'h12,       18, 1'b0};

        bus.i_valid  = 1'b0;
        bus.i_op     = 4'd0;
        bus.i_rs_val = '0;
        bus.i_rt_val = '0;
        bus.i_cancel = 1'b0;
        m_hi = '0;
        m_lo = '0;
        nrst = 1'b0;
        #1;
        check("reset busy", 64'(bus.o_busy), 64'd0);
        check("reset rd_valid", 64'(bus.o_rd_valid), 64'd0);
        check("reset rd_val", 64'(bus.o_rd_val), 64'd0);
        check("reset dz", 64'(bus.o_dz), 64'd0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        check_hilo("after reset", 32'h0, 32'h0);

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt, lat, dz);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d dz", i), 64'(dz), 64'(vecs[i].dz));
            check_hilo($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
        end

        // MFLO held under stall, accepted right after completion.
        @(negedge clk);
        bus.i_valid  = 1'b1;
        bus.i_op     = 4'd5;
        bus.i_rs_val = 32'h1234_5678;
        bus.i_rt_val = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        model(4'd5, 32'h1234_5678, 32'h9ABC_DEF0);
        bus.i_op = 4'd2;
        stall_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.o_stall) stall_cnt++;
            else break;
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_op    = 4'd0;
        check("stall cycles", 64'(stall_cnt), 64'(N + 1));
        check("b2b rd_valid", 64'(bus.o_rd_valid), 64'd1);
        check("b2b MFLO value", 64'(bus.o_rd_val), 64'(m_lo));

        // Cancel a divide at cycle 5; presented MTHI is dropped.
        @(negedge clk);
        bus.i_valid  = 1'b1;
        bus.i_op     = 4'd7;
        bus.i_rs_val = 32'd1000;
        bus.i_rt_val = 32'd3;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("busy before cancel", 64'(bus.o_busy), 64'd1);
        bus.i_cancel = 1'b1;
        bus.i_valid  = 1'b1;
        bus.i_op     = 4'd3;
        bus.i_rs_val = 32'hDEAD_BEEF;
        #1;
        check("no stall under cancel", 64'(bus.o_stall), 64'd0);
        @(posedge clk);
        #1;
        check("busy after cancel", 64'(bus.o_busy), 64'd0);
        check("no dz on cancel", 64'(bus.o_dz), 64'd0);
        bus.i_cancel = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_op     = 4'd0;
        repeat (40) @(posedge clk);
        check_hilo("after cancel", m_hi, m_lo);

        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(3, 12));
            case ($urandom_range(0, 3))
                0: rt = 32'($urandom_range(0, 3));
                1: rt = 32'hFFFF_FFFF;
                default: rt = $urandom;
            endcase
            rs = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            issue(op, rs, rt, lat, dz);
            check($sformatf("rnd%0d op%0d latency", i, op), 64'(lat), 64'(m_lat));
            check($sformatf("rnd%0d op%0d dz", i, op), 64'(dz), 64'(m_dz));
            check_hilo($sformatf("rnd%0d op%0d", i, op), m_hi, m_lo);
        end

        // Asynchronous reset in the middle of a multiply.
        issue(4'd4, 32'h55, 32'h0, lat, dz);
        read(4'd2, rs);
        check("pre-reset MFLO", 64'(rs), 64'h55);
        @(negedge clk);
        bus.i_valid  = 1'b1;
        bus.i_op     = 4'd6;
        bus.i_rs_val = 32'hABCD;
        bus.i_rt_val = 32'h1234;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check("mid reset busy", 64'(bus.o_busy), 64'd0);
        check("mid reset rd_val", 64'(bus.o_rd_val), 64'd0);
        check("mid reset rd_valid", 64'(bus.o_rd_valid), 64'd0);
        check("mid reset dz", 64'(bus.o_dz), 64'd0);
        @(negedge clk);
        nrst = 1'b1;
        m_hi = '0;
        m_lo = '0;
        check_hilo("after mid reset", m_hi, m_lo);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
